// File: rtl/dcache_pkg.sv
// dcache_pkg
// Shared definitions for the direct-mapped data cache controller.
// Contents: FSM state encoding, default geometry and address-split helpers.
package dcache_pkg;

  localparam int LINES   = 16;
  localparam int INDEX_W = $clog2(LINES);
  localparam int TAG_W   = 32 - INDEX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WRITEBACK,
    S_ALLOCATE,
    S_FILL
  } state_t;

  // Low address bits select the line.
  function automatic logic [INDEX_W-1:0] idx_f(input logic [31:0] addr);
    return addr[INDEX_W-1:0];
  endfunction

  // Remaining upper bits form the tag.
  function automatic logic [TAG_W-1:0] tag_f(input logic [31:0] addr);
    return addr[31:INDEX_W];
  endfunction

endpackage

// File: rtl/dcache_if.sv
// dcache_if
// Bundles the LSU-side request/response and the DRAM-side handshake.
//   cpu_req/cpu_we/cpu_addr/cpu_wdata : LSU request
//   cpu_ready/cpu_rdata               : completion pulse and load data
//   mem_req/lsu_operator/mem_address/write_data_int : DRAM request
//   mem_ready/dram_data_out           : DRAM accept and registered read data
// Modports: slave = cache controller view, master = LSU/DRAM view.
interface dcache_if #(
  parameter int DATA_W = 11,
  parameter int MEMW_W = 32
);

  logic              cpu_req;
  logic              cpu_we;
  logic [31:0]       cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic [DATA_W-1:0] cpu_rdata;

  logic              mem_req;
  logic              lsu_operator;
  logic [31:0]       mem_address;
  logic [MEMW_W-1:0] write_data_int;
  logic              mem_ready;
  logic [DATA_W-1:0] dram_data_out;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ready, dram_data_out,
    output cpu_ready, cpu_rdata, mem_req, lsu_operator, mem_address, write_data_int
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ready, dram_data_out,
    input  cpu_ready, cpu_rdata, mem_req, lsu_operator, mem_address, write_data_int
  );

endinterface

// File: rtl/dcache_array.sv
// dcache_array
// Line storage: valid, dirty, tag and data per line.
//   clk, rst_n                 : clock, async active-low reset (valid/dirty only)
//   i_rd_idx -> o_valid/o_dirty/o_tag/o_data : combinational read port
//   i_wr_idx, i_*_we, i_valid/i_dirty/i_tag/i_data : synchronous write port
//                                with independent per-field enables
module dcache_array #(
  parameter int LINES  = 16,
  parameter int IDX_W  = $clog2(LINES),
  parameter int TAG_W  = 32 - IDX_W,
  parameter int DATA_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic              o_valid,
  output logic              o_dirty,
  output logic [TAG_W-1:0]  o_tag,
  output logic [DATA_W-1:0] o_data,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic              i_valid_we,
  input  logic              i_dirty_we,
  input  logic              i_tag_we,
  input  logic              i_data_we,
  input  logic              i_valid,
  input  logic              i_dirty,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic [DATA_W-1:0] i_data
);

  logic [LINES-1:0]  r_valid;
  logic [LINES-1:0]  r_dirty;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [DATA_W-1:0] r_data [LINES];

  // Only the status bits need a defined reset value; a line with valid=0
  // never exposes its tag or data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if (i_valid_we) r_valid[i_wr_idx] <= i_valid;
      if (i_dirty_we) r_dirty[i_wr_idx] <= i_dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (i_tag_we)  r_tag[i_wr_idx]  <= i_tag;
    if (i_data_we) r_data[i_wr_idx] <= i_data;
  end

  assign o_valid = r_valid[i_rd_idx];
  assign o_dirty = r_dirty[i_rd_idx];
  assign o_tag   = r_tag[i_rd_idx];
  assign o_data  = r_data[i_rd_idx];

endmodule

// File: rtl/dcache_controller.sv
// dcache_controller
// Direct-mapped, write-back, write-allocate data cache in front of the DRAM.
//   clk, rst_n          : clock, async active-low reset
//   bus (dcache_if.slave): LSU request/response and DRAM handshake
//   hit_cnt/miss_cnt/wb_cnt : saturating event counters
module dcache_controller #(
  parameter int DATA_W = 11,
  parameter int LINES  = 16,
  parameter int MEMW_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  dcache_if.slave          bus,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] wb_cnt
);

  import dcache_pkg::*;

  localparam int IDX_W = $clog2(LINES);
  localparam int TW    = 32 - IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            r_state;
  state_t            w_next;
  logic              r_we;
  logic [31:0]       r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_cpu_ready;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [CNT_W-1:0]  r_hit;
  logic [CNT_W-1:0]  r_miss;
  logic [CNT_W-1:0]  r_wb;

  logic [IDX_W-1:0]  w_idx;
  logic [TW-1:0]     w_tag;
  logic              w_valid;
  logic              w_dirty;
  logic [TW-1:0]     w_line_tag;
  logic [DATA_W-1:0] w_line_data;
  logic              w_hit;

  logic              w_wr_valid;
  logic              w_wr_dirty;
  logic              w_wr_tag;
  logic              w_wr_data;
  logic              w_valid_in;
  logic              w_dirty_in;
  logic [DATA_W-1:0] w_data_in;
  logic              w_hit_evt;
  logic              w_miss_evt;
  logic              w_wb_evt;

  // All lookups and updates target the line of the latched request.
  assign w_idx = idx_f(r_addr);
  assign w_tag = tag_f(r_addr);
  assign w_hit = w_valid && (w_line_tag == w_tag);

  dcache_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TW),
    .DATA_W(DATA_W)
  ) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_rd_idx  (w_idx),
    .o_valid   (w_valid),
    .o_dirty   (w_dirty),
    .o_tag     (w_line_tag),
    .o_data    (w_line_data),
    .i_wr_idx  (w_idx),
    .i_valid_we(w_wr_valid),
    .i_dirty_we(w_wr_dirty),
    .i_tag_we  (w_wr_tag),
    .i_data_we (w_wr_data),
    .i_valid   (w_valid_in),
    .i_dirty   (w_dirty_in),
    .i_tag     (w_tag),
    .i_data    (w_data_in)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // DRAM outputs are a pure decode of the state so they hold steady for as
  // long as the DRAM withholds mem_ready.
  always_comb begin
    w_next             = r_state;
    w_wr_valid         = 1'b0;
    w_wr_dirty         = 1'b0;
    w_wr_tag           = 1'b0;
    w_wr_data          = 1'b0;
    w_valid_in         = 1'b0;
    w_dirty_in         = 1'b0;
    w_data_in          = r_wdata;
    w_hit_evt          = 1'b0;
    w_miss_evt         = 1'b0;
    w_wb_evt           = 1'b0;
    bus.mem_req        = 1'b0;
    bus.lsu_operator   = 1'b0;
    bus.mem_address    = '0;
    bus.write_data_int = '0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.cpu_req) w_next = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (w_hit) begin
          w_hit_evt = 1'b1;
          w_next    = S_IDLE;
          if (r_we) begin
            w_wr_data  = 1'b1;
            w_wr_dirty = 1'b1;
            w_dirty_in = 1'b1;
          end
        end else begin
          w_miss_evt = 1'b1;
          w_next     = (w_valid && w_dirty) ? S_WRITEBACK : S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        bus.mem_req        = 1'b1;
        bus.lsu_operator   = 1'b1;
        bus.mem_address    = {w_line_tag, w_idx};
        bus.write_data_int = {{(MEMW_W-DATA_W){1'b0}}, w_line_data};
        if (bus.mem_ready) begin
          w_wr_dirty = 1'b1;
          w_wb_evt   = 1'b1;
          w_next     = S_ALLOCATE;
        end
      end
      S_ALLOCATE: begin
        bus.mem_req     = 1'b1;
        bus.mem_address = r_addr;
        if (bus.mem_ready) w_next = S_FILL;
      end
      S_FILL: begin
        // DRAM read data is registered, so it is valid exactly in this cycle.
        w_wr_valid = 1'b1;
        w_wr_dirty = 1'b1;
        w_wr_tag   = 1'b1;
        w_wr_data  = 1'b1;
        w_valid_in = 1'b1;
        w_data_in  = bus.dram_data_out;
        w_next     = S_LOOKUP;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch plus the registered completion pulse; cpu_ready rises with
  // the return to IDLE, which allows a back-to-back request in that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_ready <= 1'b0;
      r_cpu_rdata <= '0;
    end else begin
      r_cpu_ready <= 1'b0;
      if (r_state == S_IDLE && bus.cpu_req) begin
        r_we    <= bus.cpu_we;
        r_addr  <= bus.cpu_addr;
        r_wdata <= bus.cpu_wdata;
      end
      if (r_state == S_LOOKUP && w_hit) begin
        r_cpu_ready <= 1'b1;
        if (!r_we) r_cpu_rdata <= w_line_data;
      end
    end
  end

  // Event counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit  <= '0;
      r_miss <= '0;
      r_wb   <= '0;
    end else begin
      if (w_hit_evt  && r_hit  != CNT_MAX) r_hit  <= r_hit  + 1'b1;
      if (w_miss_evt && r_miss != CNT_MAX) r_miss <= r_miss + 1'b1;
      if (w_wb_evt   && r_wb   != CNT_MAX) r_wb   <= r_wb   + 1'b1;
    end
  end

  assign bus.cpu_ready = r_cpu_ready;
  assign bus.cpu_rdata = r_cpu_rdata;
  assign hit_cnt       = r_hit;
  assign miss_cnt      = r_miss;
  assign wb_cnt        = r_wb;

endmodule
